// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback and drives every datapath select.
// Optional ILLEGAL_TRAP_EN: unrecognised instructions halt the CPU instead of executing as a NOP.
module mips_control_fsm #(
  parameter int RESET_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        OUTLSB,
  input  logic        stall,
  input  logic        pc_zero,
  input  logic        waitrequest,
  output logic        PcEn,
  output logic        IorD,
  output logic        IrWrite,
  output logic        IrSel,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        ExtSel,
  output logic        ALUsel,
  output logic        PCSrc,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic        mem_read,
  output logic        mem_write,
  output logic        active,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_STALLW = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALTED;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t     r_state;
  logic [3:0] r_wait;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_is_rtype, w_funct_ok, w_is_muldiv, w_is_jr;
  logic       w_is_imm, w_is_imm_z, w_is_lw, w_is_sw, w_is_mem, w_is_br, w_is_j;
  logic       w_legal;
  logic [3:0] w_imm_alu;
  logic       w_unused_instr;

  assign w_op           = Instr[31:26];
  assign w_funct        = Instr[5:0];
  assign w_unused_instr = ^Instr[25:6];

  always_comb begin
    w_funct_ok = 1'b0;
    case (w_funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h12,
      6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: w_funct_ok = 1'b1;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_imm_alu = 4'h0;
    case (w_op)
      6'h09:   w_imm_alu = 4'h0;
      6'h0A:   w_imm_alu = 4'h5;
      6'h0B:   w_imm_alu = 4'h6;
      6'h0C:   w_imm_alu = 4'h2;
      6'h0D:   w_imm_alu = 4'h3;
      6'h0E:   w_imm_alu = 4'h4;
      6'h0F:   w_imm_alu = 4'h7;
      default: w_imm_alu = 4'h0;
    endcase
  end

  assign w_is_rtype  = (w_op == 6'h00) && w_funct_ok;
  assign w_is_muldiv = w_is_rtype && (w_funct[5:2] == 4'b0110);
  assign w_is_jr     = w_is_rtype && (w_funct == 6'h08);
  assign w_is_imm    = (w_op >= 6'h09) && (w_op <= 6'h0F);
  assign w_is_imm_z  = (w_op >= 6'h0C) && (w_op <= 6'h0F);
  assign w_is_lw     = (w_op == 6'h23);
  assign w_is_sw     = (w_op == 6'h2B);
  assign w_is_mem    = w_is_lw || w_is_sw;
  assign w_is_br     = (w_op == 6'h04) || (w_op == 6'h05);
  assign w_is_j      = (w_op == 6'h02);
  assign w_legal     = w_is_rtype || w_is_imm || w_is_mem || w_is_br || w_is_j;

  // Memory handshake: mem_read/mem_write and every other control are held while
  // waitrequest=1; the access completes on the first cycle waitrequest=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wait  <= 4'(RESET_WAIT);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_wait <= 4'd1) r_state <= S_FETCH;
          else                r_wait  <= r_wait - 4'd1;
        end
        S_FETCH: begin
          if (pc_zero)           r_state <= S_HALTED;
          else if (!waitrequest) r_state <= S_DECODE;
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (!w_legal)                          r_state <= ILLEGAL_NEXT;
          else if (w_is_muldiv)                  r_state <= S_STALLW;
          else if (w_is_mem)                     r_state <= S_MEM;
          else if (w_is_jr || w_is_br || w_is_j) r_state <= S_FETCH;
          else                                   r_state <= S_WB;
        end
        S_STALLW: if (!stall) r_state <= S_FETCH;
        S_MEM: begin
          if (!waitrequest) r_state <= w_is_lw ? S_WB : S_FETCH;
        end
        S_WB:     r_state <= S_FETCH;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PcEn = 1'b0; IorD = 1'b0; IrWrite = 1'b0; IrSel = 1'b0; RegDst = 1'b0;
    MemToReg = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; ExtSel = 1'b0;
    ALUsel = 1'b0; PCSrc = 1'b0; ALUSrcB = 2'b00; ALUControl = 4'h0;
    mem_read = 1'b0; mem_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!pc_zero) begin
          mem_read = 1'b1;
          ALUSrcB  = 2'b01;
          if (!waitrequest) begin
            IrWrite = 1'b1;
            PcEn    = 1'b1;
          end
        end
      end
      S_DECODE: begin
        IrSel   = 1'b1;
        ALUSrcB = 2'b11;
      end
      // IrSel stays 1 after DECODE so Instr is taken from the latched IR.
      S_EXEC: begin
        IrSel = 1'b1;
        if (w_is_rtype) begin
          ALUSrcA    = 1'b1;
          ALUControl = 4'hF;
          PcEn       = w_is_jr;
        end else if (w_is_imm) begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ExtSel     = w_is_imm_z;
          ALUControl = w_imm_alu;
        end else if (w_is_mem) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end else if (w_is_br) begin
          ALUSrcA    = 1'b1;
          ALUControl = w_op[0] ? 4'hA : 4'h9;
          PcEn       = OUTLSB;
          PCSrc      = 1'b1;
        end else if (w_is_j) begin
          PcEn   = 1'b1;
          PCSrc  = 1'b1;
          ALUsel = 1'b1;
        end
      end
      S_STALLW: begin
        IrSel      = 1'b1;
        ALUSrcA    = 1'b1;
        ALUControl = 4'hF;
      end
      S_MEM: begin
        IrSel     = 1'b1;
        IorD      = 1'b1;
        ALUsel    = 1'b1;
        mem_read  = w_is_lw;
        mem_write = w_is_sw && !w_is_lw;
      end
      S_WB: begin
        IrSel    = 1'b1;
        RegWrite = 1'b1;
        MemToReg = !w_is_lw;
        RegDst   = w_is_rtype;
      end
      default: ;
    endcase
  end

  assign active      = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign o_dbg_state = r_state;

endmodule
